// File: rtl/echo_distance.sv
// Ultrasonic echo timer: measures echo pulse width in whole cm and maps it to a paddle Y position.
// Optional ECHO_AVG_EN adds a 4-sample moving average of the distance ahead of the mapping.
module echo_distance #(
  parameter int unsigned CYCLES_PER_CM = 3770,
  parameter int unsigned RISE_TIMEOUT  = 65000,
  parameter int unsigned MIN_CM        = 5,
  parameter int unsigned MAX_CM        = 45,
  parameter int unsigned PX_PER_CM     = 16,
  parameter int unsigned Y_MAX         = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        echo,
  output logic        busy,
  output logic        valid,
  output logic [8:0]  distance_cm,
  output logic [11:0] paddle_y,
  output logic        timeout
);

  localparam int unsigned CntMax = (RISE_TIMEOUT > CYCLES_PER_CM) ? RISE_TIMEOUT : CYCLES_PER_CM;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] RiseLast = CntW'(RISE_TIMEOUT - 1);
  localparam logic [CntW-1:0] CmLast   = CntW'(CYCLES_PER_CM - 1);
  localparam logic [8:0]      MaxCm    = 9'(MAX_CM);
  localparam logic [8:0]      MinCm    = 9'(MIN_CM);
  localparam logic [7:0]      PxPerCm  = 8'(PX_PER_CM);
  localparam logic [16:0]     YMax17   = 17'(Y_MAX);
  localparam logic [11:0]     YMax12   = 12'(Y_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRise,
    StMeasure,
    StAverage,
    StConvert,
    StDone
  } state_e;

`ifdef ECHO_AVG_EN
  localparam state_e StPost = StAverage;
`else
  localparam state_e StPost = StConvert;
`endif

  function automatic logic [11:0] map_y(input logic [8:0] d);
    logic [8:0]  dc;
    logic [16:0] prod;
    dc   = (d < MinCm) ? MinCm : d;
    prod = {8'b0, dc - MinCm} * {9'b0, PxPerCm};
    return (prod > YMax17) ? YMax12 : prod[11:0];
  endfunction

  state_e          state_q, state_d;
  logic            echo_meta_q, echo_s_q;
  logic [CntW-1:0] cyc_q, cyc_d;
  logic [8:0]      cm_q, cm_d;
  logic [8:0]      sample_q, sample_d;
  logic            abort_q, abort_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [8:0]      dist_q, dist_d;
  logic [11:0]     y_q, y_d;
  logic            timeout_q, timeout_d;
  logic [8:0]      conv_src;

`ifdef ECHO_AVG_EN
  logic [8:0]  hist_q [4];
  logic [8:0]  hist_d [4];
  logic        primed_q, primed_d;
  logic [8:0]  avg_q, avg_d;
  logic [10:0] avg_sum;
  assign conv_src = avg_q;
`else
  assign conv_src = sample_q;
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cm_d      = cm_q;
    sample_d  = sample_q;
    abort_d   = abort_q;
    dist_d    = dist_q;
    y_d       = y_q;
    timeout_d = timeout_q;
`ifdef ECHO_AVG_EN
    hist_d    = hist_q;
    primed_d  = primed_q;
    avg_d     = avg_q;
    avg_sum   = '0;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitRise;
          cyc_d   = '0;
          cm_d    = '0;
        end
      end
      StWaitRise: begin
        if (echo_s_q) begin
          // The rise cycle itself is the first counted cycle of echo-high.
          state_d = StMeasure;
          cyc_d   = CntW'(1);
          cm_d    = '0;
        end else if (cyc_q == RiseLast) begin
`ifdef ECHO_AVG_EN
          sample_d  = MaxCm;
          abort_d   = 1'b1;
          state_d   = StAverage;
`else
          dist_d    = MaxCm;
          y_d       = map_y(MaxCm);
          timeout_d = 1'b1;
          state_d   = StDone;
`endif
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StMeasure: begin
        if (!echo_s_q) begin
          sample_d = cm_q;
          abort_d  = 1'b0;
          state_d  = StPost;
        end else if (cm_q == MaxCm) begin
          sample_d = MaxCm;
          abort_d  = 1'b1;
          state_d  = StPost;
        end else if (cyc_q == CmLast) begin
          cyc_d = '0;
          cm_d  = cm_q + 9'd1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`ifdef ECHO_AVG_EN
      StAverage: begin
        // First sample after reset fills the whole window so the average starts settled.
        if (!primed_q) begin
          for (int i = 0; i < 4; i++) hist_d[i] = sample_q;
        end else begin
          hist_d[0] = sample_q;
          for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
        end
        primed_d = 1'b1;
        avg_sum  = {2'b0, hist_d[0]} + {2'b0, hist_d[1]} + {2'b0, hist_d[2]} + {2'b0, hist_d[3]};
        avg_d    = avg_sum[10:2];
        state_d  = StConvert;
      end
`endif
      StConvert: begin
        dist_d    = conv_src;
        y_d       = map_y(conv_src);
        timeout_d = abort_q;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      cyc_q       <= '0;
      cm_q        <= '0;
      sample_q    <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      dist_q      <= '0;
      y_q         <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      cyc_q       <= cyc_d;
      cm_q        <= cm_d;
      sample_q    <= sample_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      dist_q      <= dist_d;
      y_q         <= y_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef ECHO_AVG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q   <= '{default: '0};
      primed_q <= 1'b0;
      avg_q    <= '0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= primed_d;
      avg_q    <= avg_d;
    end
  end
`endif

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign distance_cm = dist_q;
  assign paddle_y    = y_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/echo_distance.md
Name: echo_distance

Overview:
- Downstream consumer of the ultrasonic `sensor` trigger stage.
- Times the sensor's echo pulse after each trigger, converts the width to whole centimetres, and maps the distance to a paddle Y coordinate for the PONG game logic.
- Runs at the 65 MHz pixel clock and delivers one result per measurement with a single-cycle valid strobe.

Parameters:
- CYCLES_PER_CM, 3770, clock cycles of echo-high per centimetre (58 us at 65 MHz)
- RISE_TIMEOUT, 65000, max cycles waiting for echo rise after start (1 ms)
- MIN_CM, 5, distance mapped to paddle_y = 0
- MAX_CM, 45, saturation distance; also the measurement abort limit
- PX_PER_CM, 16, paddle pixels per centimetre
- Y_MAX, 640, maximum paddle_y (768 - 128 paddle height)

Ports:
- clk  input  1  65 MHz system clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  one-cycle pulse on the trigger falling edge
- echo  input  1  raw sensor echo pin, asynchronous
- busy  output  1  high while a measurement is in progress
- valid  output  1  one-cycle strobe; distance_cm and paddle_y updated
- distance_cm  output  9  measured distance in cm, saturated at MAX_CM
- paddle_y  output  12  mapped paddle position, held between strobes
- timeout  output  1  sticky flag: last measurement had no echo or was out of range

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, valid=0, distance_cm=0, paddle_y=0, timeout=0; all counters cleared.
- Echo input: 2-FF synchroniser on echo. All logic uses the synchronised value echo_s.
- IDLE:
  - start=1 -> WAIT_RISE; clear the cycle counter and the cm counter.
  - echo_s ignored.
- WAIT_RISE:
  - echo_s=1 -> MEASURE.
  - Wait counter reaches RISE_TIMEOUT-1 -> DONE with timeout=1 and distance_cm=MAX_CM.
- MEASURE:
  - Prescaler counts 0..CYCLES_PER_CM-1; on wrap, cm counter +1.
  - echo_s=0 -> CONVERT with distance = cm counter (truncating).
  - cm counter reaches MAX_CM -> CONVERT with distance=MAX_CM and timeout=1; the remaining echo is not waited for.
- CONVERT (1 cycle):
  - d_clamped = max(distance, MIN_CM).
  - y = (d_clamped - MIN_CM) * PX_PER_CM, clamped to Y_MAX.
  - Register the result, then go to DONE.
- DONE (1 cycle):
  - Drive outputs and pulse valid=1 for one cycle.
  - timeout updates: set on abort, cleared on a good measurement.
  - Return to IDLE.
- Latency: echo_s falling at cycle N -> valid=1 at cycle N+2.
- busy=1 in every state except IDLE; it drops in the same cycle the FSM returns to IDLE.
- start while busy: ignored, no queuing.
- start and echo_s rising in the same cycle while IDLE: only start acts; the rise is sampled the next cycle in WAIT_RISE.
- Echo already high when start arrives: WAIT_RISE moves straight to MEASURE on the next cycle, so the measurement is partial. This is acceptable.
- Reset mid-measurement: immediate return to IDLE with all outputs at reset values.
- Arithmetic: the multiply runs at 9x8 bits into a 17-bit intermediate, then is clamped to 12 bits; no overflow is possible with the defaults.

Optional Feature:
- Macro: ECHO_AVG_EN.
- Defined:
  - 4-entry moving average of distance_cm before mapping. A 4-deep shift register is summed and shifted right by 2 (truncating).
  - The first valid result after reset preloads all 4 entries with that sample.
  - Timeout/abort samples do enter the average at value MAX_CM.
  - Adds one pipeline stage: valid at N+3.
- Undefined: no averaging; latency N+2; the averaging registers are absent.

Test Plan:
- Reset values: assert rst=0 mid-MEASURE -> busy=0, valid=0, distance_cm=0, paddle_y=0, timeout=0 immediately, asynchronously.
- Normal measurement (CYCLES_PER_CM=10): start, echo high after 20 cycles for 200 cycles -> valid once, distance_cm=20, paddle_y=240, timeout=0, valid exactly 2 cycles after echo_s falls.
- No echo (RISE_TIMEOUT=100): start, echo held low -> valid after 100 cycles, distance_cm=45, paddle_y=640, timeout=1.
- Long echo (CYCLES_PER_CM=10): echo high 1000 cycles -> aborts at 450 cycles, distance_cm=45, timeout=1. A following 100-cycle echo -> distance_cm=10, paddle_y=80, timeout=0.
- Near / busy: echo 30 cycles (3 cm) -> distance_cm=3, paddle_y=0. A second start pulse during MEASURE -> ignored, only one valid strobe.
- ECHO_AVG_EN: echo widths 100, 200, 200, 200 cycles -> distance_cm 10, 12, 15, 17 on successive valid strobes. The first strobe preloads all 4 entries with 10, so the averages are (10+10+10+10)/4, (10+10+10+20)/4, (10+10+20+20)/4, (10+20+20+20)/4, truncated.
